// File: rtl/uart_tx_frame_if.sv
// Host-side handshake of the UART transmitter: word valid/data in, ready/active/line/done out.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_TX_DV;
  logic [DATA_BITS-1:0] i_TX_Byte;
  logic                 o_TX_Ready;
  logic                 o_TX_Active;
  logic                 o_TX_Serial;
  logic                 o_TX_Done;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: LSB-first frames with optional parity, 1/2 stop bits and a one-word
// holding register so consecutive frames leave the pin with no idle gap.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic          i_Clock,
  input logic          i_Rst_L,
  uart_tx_frame_if.slave tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic                 fin_q, fin_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic                 accept, bit_end, last_stop, load;
  logic [DATA_BITS-1:0] load_word;

  assign accept    = tx.i_TX_DV && !hold_full_q;
  assign bit_end   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign last_stop = (state_q == STOP) && bit_end && (stop_idx_q == 1'(STOP_BITS - 1));

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    fin_d       = 1'b0;
    load        = 1'b0;
    load_word   = tx.i_TX_Byte;

    if (state_q == IDLE) begin
      load = accept;
    end else begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
      if (last_stop) begin
        // Frame boundary: a queued word (or one offered right now) starts without a gap.
        fin_d = 1'b1;
        if (hold_full_q) begin
          load        = 1'b1;
          load_word   = hold_q;
          hold_full_d = 1'b0;
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end else begin
        if (accept) begin
          hold_d      = tx.i_TX_Byte;
          hold_full_d = 1'b1;
        end
        if (bit_end) begin
          case (state_q)
            START: begin
              state_d   = DATA;
              bit_idx_d = '0;
            end
            DATA: begin
              shift_d = shift_q >> 1;
              if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                state_d    = (PARITY != 0) ? PAR : STOP;
                stop_idx_d = 1'b0;
              end else begin
                bit_idx_d = bit_idx_q + 1'b1;
              end
            end
            PAR: begin
              state_d    = STOP;
              stop_idx_d = 1'b0;
            end
            STOP:    stop_idx_d = stop_idx_q + 1'b1;
            default: state_d = IDLE;
          endcase
        end
      end
    end

    if (load) begin
      state_d    = START;
      clk_cnt_d  = '0;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      shift_d    = load_word;
      par_d      = (PARITY == 2) ? ~^load_word : ^load_word;
    end
  end

  // Pin outputs are registered from the current state, so the line lags the FSM by one edge.
  always_comb begin
    case (state_q)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_q[0];
      PAR:     serial_d = par_q;
      default: serial_d = 1'b1;
    endcase
    active_d = (state_q != IDLE);
    done_d   = fin_q;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      fin_q       <= 1'b0;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      fin_q       <= fin_d;
      serial_q    <= serial_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign tx.o_TX_Ready  = !hold_full_q;
  assign tx.o_TX_Active = active_q;
  assign tx.o_TX_Serial = serial_q;
  assign tx.o_TX_Done   = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7N2) checked every cycle
// against a bit-queue frame model, plus hand-computed pin values for each scenario.
module tb_uart_tx_frame;
  localparam int CLKS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] dv;
  logic [8:0] wd [4];

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
  uart_tx_frame_if #(.DATA_BITS(7)) if3 ();

  assign if0.i_TX_DV = dv[0];  assign if0.i_TX_Byte = wd[0][7:0];
  assign if1.i_TX_DV = dv[1];  assign if1.i_TX_Byte = wd[1][7:0];
  assign if2.i_TX_DV = dv[2];  assign if2.i_TX_Byte = wd[2][7:0];
  assign if3.i_TX_DV = dv[3];  assign if3.i_TX_Byte = wd[3][6:0];

  wire [3:0] ser = {if3.o_TX_Serial, if2.o_TX_Serial, if1.o_TX_Serial, if0.o_TX_Serial};
  wire [3:0] act = {if3.o_TX_Active, if2.o_TX_Active, if1.o_TX_Active, if0.o_TX_Active};
  wire [3:0] dne = {if3.o_TX_Done,   if2.o_TX_Done,   if1.o_TX_Done,   if0.o_TX_Done};
  wire [3:0] rdy = {if3.o_TX_Ready,  if2.o_TX_Ready,  if1.o_TX_Ready,  if0.o_TX_Ready};

  uart_tx_frame #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.i_Clock(clk), .i_Rst_L(rst_n), .tx(if0));
  uart_tx_frame #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u1 (.i_Clock(clk), .i_Rst_L(rst_n), .tx(if1));
  uart_tx_frame #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u2 (.i_Clock(clk), .i_Rst_L(rst_n), .tx(if2));
  uart_tx_frame #(.CLKS_PER_BIT(CLKS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u3 (.i_Clock(clk), .i_Rst_L(rst_n), .tx(if3));

  int cdb  [4] = '{8, 8, 8, 7};
  int cpar [4] = '{0, 1, 2, 0};
  int csb  [4] = '{1, 1, 1, 2};

  int checks   = 0;
  int failures = 0;

  task automatic chk(string nm, int d, logic a, logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%b exp=%b", nm, d, $time, a, e);
    end
  endtask

  // Model: each accepted word becomes a list of line levels, one entry per clock,
  // the final entry tagged as frame end; a waiting word sits in pend/hold_w.
  bit [1:0]   mq [4][$];
  bit         pend [4];
  bit [8:0]   hold_w [4];
  bit         prev_last [4];
  bit         e_ser [4], e_act [4], e_dne [4], e_rdy [4];

  task automatic push_frame(int d, bit [8:0] w);
    bit b[$];
    int ones;
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < cdb[d]; i++) begin
      b.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (cpar[d] == 1) b.push_back((ones % 2) == 1);
    if (cpar[d] == 2) b.push_back((ones % 2) == 0);
    for (int i = 0; i < csb[d]; i++) b.push_back(1'b1);
    for (int j = 0; j < b.size(); j++)
      for (int c = 0; c < CLKS; c++)
        mq[d].push_back({(j == b.size() - 1) && (c == CLKS - 1), b[j]});
  endtask

  task automatic model_clear();
    for (int d = 0; d < 4; d++) begin
      mq[d].delete();
      pend[d] = 1'b0;
      prev_last[d] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 4; d++) begin
        bit [1:0] ent;
        bit have, acc;
        acc  = dv[d] && !pend[d];
        have = mq[d].size() > 0;
        ent  = 2'b01;
        if (have) ent = mq[d].pop_front();
        e_dne[d]     = prev_last[d];
        prev_last[d] = have && ent[1];
        e_ser[d]     = ent[0];
        e_act[d]     = have;
        if (mq[d].size() > 0) begin
          if (acc) begin
            pend[d]   = 1'b1;
            hold_w[d] = wd[d];
          end
        end else if (pend[d]) begin
          push_frame(d, hold_w[d]);
          pend[d] = 1'b0;
        end else if (acc) begin
          push_frame(d, wd[d]);
        end
        e_rdy[d] = !pend[d];
      end
    end
    #1;
    if (rst_n) begin
      for (int d = 0; d < 4; d++) begin
        chk("m_serial", d, ser[d], e_ser[d]);
        chk("m_active", d, act[d], e_act[d]);
        chk("m_done",   d, dne[d], e_dne[d]);
        chk("m_ready",  d, rdy[d], e_rdy[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [9:0] p55 = 10'b1010101010;

  initial begin
    rst_n = 1'b0;
    dv    = '0;
    for (int d = 0; d < 4; d++) wd[d] = '0;
    model_clear();
    repeat (3) tick();
    for (int d = 0; d < 4; d++) begin
      chk("rst_serial", d, ser[d], 1'b1);
      chk("rst_active", d, act[d], 1'b0);
      chk("rst_done",   d, dne[d], 1'b0);
      chk("rst_ready",  d, rdy[d], 1'b1);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // 0x55 on 8N1, 0x07 on 8E1/8O1, 0x41 on 7N2, all accepted at the same edge
    dv = 4'b1111;
    wd[0] = 9'h055; wd[1] = 9'h007; wd[2] = 9'h007; wd[3] = 9'h041;
    tick();
    dv = '0;
    for (int d = 0; d < 4; d++) wd[d] = 9'h1AA;
    for (int k = 1; k <= 46; k++) begin
      tick();
      if (k % 4 == 2 && k <= 40) chk("p55_bit", 0, ser[0], p55[(k - 1) / 4]);
      if (k == 40) begin
        chk("p55_act_last", 0, act[0], 1'b1);
        chk("p55_no_done",  0, dne[0], 1'b0);
        chk("n72_stop2",    3, ser[3], 1'b1);
        chk("n72_act_last", 3, act[3], 1'b1);
      end
      if (k == 41) begin
        chk("p55_done",   0, dne[0], 1'b1);
        chk("p55_idle",   0, act[0], 1'b0);
        chk("n72_done",   3, dne[3], 1'b1);
        chk("n72_idle",   3, act[3], 1'b0);
      end
      if (k == 42) chk("p55_done_once", 0, dne[0], 1'b0);
      if (k == 26) chk("n72_d5", 3, ser[3], 1'b0);
      if (k == 30) chk("n72_d6", 3, ser[3], 1'b1);
      if (k == 33) chk("n72_stop1", 3, ser[3], 1'b1);
      if (k == 38) begin
        chk("even_par", 1, ser[1], 1'b1);
        chk("odd_par",  2, ser[2], 1'b0);
      end
      if (k == 44) begin
        chk("par_act_last", 1, act[1], 1'b1);
        chk("par_no_done",  2, dne[2], 1'b0);
      end
      if (k == 45) begin
        chk("even_done", 1, dne[1], 1'b1);
        chk("odd_done",  2, dne[2], 1'b1);
        chk("par_idle",  1, act[1], 1'b0);
      end
    end

    // Back-to-back 0xA5 then 0x3C, with a 0xFF offered while the holding register is full
    repeat (3) tick();
    dv[0] = 1'b1; wd[0] = 9'h0A5;
    tick();
    dv[0] = 1'b0; wd[0] = 9'h1AA;
    for (int k = 1; k <= 84; k++) begin
      tick();
      if (k == 9)  begin dv[0] = 1'b1; wd[0] = 9'h03C; end
      if (k == 10) begin dv[0] = 1'b0; wd[0] = 9'h1AA; chk("b2b_rdy_low", 0, rdy[0], 1'b0); end
      if (k == 19) begin dv[0] = 1'b1; wd[0] = 9'h0FF; end
      if (k == 20) begin dv[0] = 1'b0; wd[0] = 9'h1AA; chk("drop_rdy_low", 0, rdy[0], 1'b0); end
      if (k == 39) chk("b2b_rdy_still_low", 0, rdy[0], 1'b0);
      if (k == 40) begin
        chk("b2b_rdy_back", 0, rdy[0], 1'b1);
        chk("b2b_stop",     0, ser[0], 1'b1);
      end
      if (k == 41) begin
        chk("b2b_start",  0, ser[0], 1'b0);
        chk("b2b_active", 0, act[0], 1'b1);
        chk("b2b_done1",  0, dne[0], 1'b1);
      end
      if (k == 42) chk("b2b_done1_once", 0, dne[0], 1'b0);
      if (k == 46) chk("b2b_3c_d0", 0, ser[0], 1'b0);
      if (k == 54) chk("b2b_3c_d2", 0, ser[0], 1'b1);
      if (k == 81) chk("b2b_done2", 0, dne[0], 1'b1);
      if (k == 82) chk("b2b_idle",  0, act[0], 1'b0);
    end

    // Reset in the middle of data bit 3 of 0xC3, then 0x5A
    dv[0] = 1'b1; wd[0] = 9'h0C3;
    tick();
    dv[0] = 1'b0; wd[0] = 9'h1AA;
    repeat (18) tick();
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("abort_serial", 0, ser[0], 1'b1);
    chk("abort_active", 0, act[0], 1'b0);
    chk("abort_ready",  0, rdy[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", 0, dne[0], 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_quiet", 0, dne[0], 1'b0);
    end
    dv[0] = 1'b1; wd[0] = 9'h05A;
    tick();
    dv[0] = 1'b0; wd[0] = 9'h1AA;
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (k == 2)  chk("p5a_start", 0, ser[0], 1'b0);
      if (k == 6)  chk("p5a_d0",    0, ser[0], 1'b0);
      if (k == 10) chk("p5a_d1",    0, ser[0], 1'b1);
      if (k == 41) chk("p5a_done",  0, dne[0], 1'b1);
    end

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
